// File: rtl/mire_gen.sv
// mire_gen: Wishbone-master test-pattern generator.
// Writes full frames of 0x00RRGGBB pixels into the framebuffer in bursts of
// up to BURST_LEN acked beats. Each tenure is followed by exactly one idle
// cycle so the bus arbiter can serve the display reader.
// Optional feature macro: MIRE_GEN_CTI_BURST_EN. When defined, cti signals an
// incrementing burst (3'b010) with an end-of-burst marker (3'b111) on the final
// beat of each tenure. When undefined, cti stays at classic cycle (3'b000).
module mire_gen #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int          BURST_LEN = 64,
  parameter int          GRID_STEP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic        we,
  output logic [3:0]  sel,
  output logic        cyc,
  output logic        stb,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  output logic        busy,
  output logic        frame_done
);

  localparam int PIX_W  = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int LINE_W = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BC_W   = $clog2(BURST_LEN);
  localparam int GS_LG  = $clog2(GRID_STEP);

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(HDISP - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(VDISP - 1);
  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(BURST_LEN - 1);
  localparam logic [31:0]       GS_MASK   = 32'(GRID_STEP - 1);

  localparam logic [23:0] WHITE = 24'hFF_FFFF;
  localparam logic [23:0] BLACK = 24'h00_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  logic [PIX_W-1:0]   pix;
  logic [LINE_W-1:0]  line;
  logic [BC_W-1:0]    bcnt;
  logic [1:0]         mode_q;
  logic [23:0]        rgb_q;
  logic               frame_cmp;

  logic               beat;
  logic               last_pix;
  logic               tenure_last;

  // Bar colour lookup: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFF_FFFF;
      3'd1:    return 24'hFF_FF00;
      3'd2:    return 24'h00_FFFF;
      3'd3:    return 24'h00_FF00;
      3'd4:    return 24'hFF_00FF;
      3'd5:    return 24'hFF_0000;
      3'd6:    return 24'h00_00FF;
      default: return 24'h00_0000;
    endcase
  endfunction

  // A beat completes when the slave acks while we hold the bus.
  assign beat        = (state == BURST) && ack;
  assign last_pix    = (pix == PIX_LAST) && (line == LINE_LAST);
  assign tenure_last = (bcnt == BC_LAST) || last_pix;

  assign stb        = cyc;
  assign we         = 1'b1;
  assign sel        = 4'b1111;
  assign bte        = 2'b00;
  assign frame_done = beat && last_pix;

`ifdef MIRE_GEN_CTI_BURST_EN
  assign cti = (state != BURST) ? 3'b000 : (tenure_last ? 3'b111 : 3'b010);
`else
  assign cti = 3'b000;
`endif

  // Bus tenure control: IDLE -> BURST -> RELEASE, with frame-start latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= 1'b0;
      bcnt      <= '0;
      mode_q    <= 2'd0;
      rgb_q     <= 24'd0;
      busy      <= 1'b0;
      frame_cmp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            mode_q <= mode;
            rgb_q  <= solid_rgb;
            busy   <= 1'b1;
            cyc    <= 1'b1;
            state  <= BURST;
          end
        end
        BURST: begin
          if (ack) begin
            bcnt <= bcnt + BC_W'(1);
            if (last_pix) frame_cmp <= 1'b1;
            if (tenure_last) begin
              cyc   <= 1'b0;
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          bcnt <= '0;
          if (frame_cmp) begin
            frame_cmp <= 1'b0;
            if (enable) begin
              mode_q <= mode;
              rgb_q  <= solid_rgb;
              cyc    <= 1'b1;
              state  <= BURST;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cyc   <= 1'b1;
            state <= BURST;
          end
        end
        default: begin
          cyc   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Raster position and byte address advance on every acked beat; the
  // address is stepped incrementally and wraps to the base after the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix  <= '0;
      line <= '0;
      adr  <= BASE_ADR;
    end else if (beat) begin
      if (pix == PIX_LAST) begin
        pix <= '0;
        if (line == LINE_LAST) line <= '0;
        else                   line <= line + LINE_W'(1);
      end else begin
        pix <= pix + PIX_W'(1);
      end
      adr <= last_pix ? BASE_ADR : adr + 32'd4;
    end
  end

  // Pixel colour from the current raster position and the latched mode.
  always_comb begin
    logic [31:0] pix32;
    logic [31:0] line32;
    logic [2:0]  bar_idx;
    logic        grid_on;
    logic        checker_on;
    pix32      = 32'(pix);
    line32     = 32'(line);
    grid_on    = ((pix32 & GS_MASK) == 32'd0) || ((line32 & GS_MASK) == 32'd0);
    checker_on = pix32[GS_LG] ^ line32[GS_LG];
    // (pix*8)/HDISP, found by counting how many bar boundaries pix*8 has passed.
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ((pix32 << 3) >= 32'(k * HDISP)) bar_idx = bar_idx + 3'd1;
    end
    case (mode_q)
      2'd0:    dat_ms = {8'h00, grid_on ? WHITE : BLACK};
      2'd1:    dat_ms = {8'h00, bar_colour(bar_idx)};
      2'd2:    dat_ms = {8'h00, checker_on ? WHITE : BLACK};
      default: dat_ms = {8'h00, rgb_q};
    endcase
  end

endmodule

// File: tb/tb_mire_gen.sv
// Testbench for mire_gen: two instances, a tiny 10x4 frame (base 0x1000,
// bursts of 16, grid step 4) and the default 800x480 configuration.
module tb_mire_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A signals
  logic        rst_a, en_a, ack_a;
  logic [1:0]  mode_a;
  logic [23:0] rgb_a;
  logic [31:0] adr_a, dat_a;
  logic        we_a, cyc_a, stb_a, busy_a, fd_a;
  logic [3:0]  sel_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;

  // Instance B signals
  logic        rst_b, en_b, ack_b;
  logic [1:0]  mode_b;
  logic [23:0] rgb_b;
  logic [31:0] adr_b, dat_b;
  logic        we_b, cyc_b, stb_b, busy_b, fd_b;
  logic [3:0]  sel_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;

  mire_gen #(.HDISP(10), .VDISP(4), .BASE_ADR(32'h0000_1000), .BURST_LEN(16), .GRID_STEP(4)) u_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .mode(mode_a), .solid_rgb(rgb_a),
    .adr(adr_a), .dat_ms(dat_a), .we(we_a), .sel(sel_a), .cyc(cyc_a), .stb(stb_a),
    .cti(cti_a), .bte(bte_a), .ack(ack_a), .busy(busy_a), .frame_done(fd_a)
  );

  mire_gen #(.HDISP(800), .VDISP(480), .BASE_ADR(32'h0000_0000), .BURST_LEN(64), .GRID_STEP(16)) u_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .mode(mode_b), .solid_rgb(rgb_b),
    .adr(adr_b), .dat_ms(dat_b), .we(we_b), .sel(sel_b), .cyc(cyc_b), .stb(stb_b),
    .cti(cti_b), .bte(bte_b), .ack(ack_b), .busy(busy_b), .frame_done(fd_b)
  );

  typedef struct {
    int          beat;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        fd;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   ten_a[$];
  int   cnt_a = 0;
  int   cnt_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rst(input string t, input logic [31:0] adr, input logic [31:0] base,
                         input logic [31:0] dat, input logic [31:0] cyc, input logic [31:0] stb,
                         input logic [31:0] busy, input logic [31:0] fd, input logic [31:0] cti,
                         input logic [31:0] we, input logic [31:0] sel, input logic [31:0] bte);
    chk({t, "_adr"}, adr, base);
    chk({t, "_dat"}, dat, 32'h00FF_FFFF);
    chk({t, "_cyc"}, cyc, 32'd0);
    chk({t, "_stb"}, stb, 32'd0);
    chk({t, "_busy"}, busy, 32'd0);
    chk({t, "_frame_done"}, fd, 32'd0);
    chk({t, "_cti"}, cti, 32'd0);
    chk({t, "_we"}, we, 32'd1);
    chk({t, "_sel"}, sel, 32'hF);
    chk({t, "_bte"}, bte, 32'd0);
  endtask

  function automatic logic [31:0] cti_for(input bit last_beat);
`ifdef MIRE_GEN_CTI_BURST_EN
    return last_beat ? 32'd7 : 32'd2;
`else
    return (last_beat && 1'b0) ? 32'd7 : 32'd0;
`endif
  endfunction

  // Expected pixel for instance A: frame 0 solid 0x123456, frame 1 grid, frame 2 checker.
  function automatic logic [31:0] exp_dat_a(input int b);
    int f, i, p, l;
    f = b / 40;
    i = b % 40;
    p = i % 10;
    l = i / 10;
    if (f == 0) return 32'h0012_3456;
    if (f == 1) return ((p % 4 == 0) || (l % 4 == 0)) ? 32'h00FF_FFFF : 32'h0;
    return ((((p / 4) ^ (l / 4)) % 2) == 1) ? 32'h00FF_FFFF : 32'h0;
  endfunction

  // Monitor A: beat scoreboard, tenure lengths, release gaps, frame_done.
  int   ten_acks = 0;
  int   gap = 0;
  logic prev_busy = 1'b0;
  logic prev_cyc = 1'b0;
  int   ia;
  exp_t ea;
  always @(negedge clk) begin
    if (rst_a) begin
      cnt_a = 0; ten_acks = 0; gap = 0; prev_busy = 1'b0; prev_cyc = 1'b0;
    end else begin
      if (cyc_a && !prev_cyc && prev_busy) chk("a_release_gap", gap, 32'd1);
      if (cyc_a) gap = 0; else gap++;
      if (!cyc_a && prev_cyc) begin
        if (ten_a.size() == 0) chk("a_unexpected_tenure_acks", ten_acks, 32'd0);
        else chk("a_tenure_len", ten_acks, ten_a.pop_front());
        ten_acks = 0;
      end
      if (cyc_a && ack_a) begin
        ia = cnt_a % 40;
        chk("a_stb", 32'(stb_a), 32'd1);
        chk("a_cti", 32'(cti_a), cti_for((ia % 16 == 15) || (ia == 39)));
        while (q_a.size() > 0 && q_a[0].beat < cnt_a) begin
          chk("a_missed_beat", q_a[0].beat, cnt_a);
          void'(q_a.pop_front());
        end
        if (q_a.size() > 0 && q_a[0].beat == cnt_a) begin
          ea = q_a.pop_front();
          chk("a_adr", adr_a, ea.adr);
          chk("a_dat", dat_a, ea.dat);
          chk("a_frame_done", 32'(fd_a), 32'(ea.fd));
        end
        cnt_a++;
        ten_acks++;
      end else begin
        chk("a_frame_done_noack", 32'(fd_a), 32'd0);
      end
      prev_cyc = cyc_a;
      prev_busy = busy_a;
    end
  end

  // Monitor B: beat scoreboard and cti on the first two tenures.
  exp_t eb;
  always @(negedge clk) begin
    if (rst_b) begin
      cnt_b = 0;
    end else if (cyc_b && ack_b) begin
      if (cnt_b < 128) chk("b_cti", 32'(cti_b), cti_for(cnt_b % 64 == 63));
      while (q_b.size() > 0 && q_b[0].beat < cnt_b) begin
        chk("b_missed_beat", q_b[0].beat, cnt_b);
        void'(q_b.pop_front());
      end
      if (q_b.size() > 0 && q_b[0].beat == cnt_b) begin
        eb = q_b.pop_front();
        chk("b_adr", adr_b, eb.adr);
        chk("b_dat", dat_b, eb.dat);
        chk("b_frame_done", 32'(fd_b), 32'(eb.fd));
      end
      cnt_b++;
    end
  end

  task automatic push_b(input int b, input logic [31:0] d);
    q_b.push_back('{beat: b, adr: 32'(4 * b), dat: d, fd: 1'b0});
  endtask

  task automatic wait_cnt(input bit on_b, input int n, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      if ((on_b ? cnt_b : cnt_a) >= n) break;
      @(posedge clk); #1;
    end
    if (k == bound) chk(on_b ? "b_timeout_beats" : "a_timeout_beats", on_b ? cnt_b : cnt_a, n);
  endtask

  initial begin
    int k;
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    ack_a = 1'b1; ack_b = 1'b1;
    mode_a = 2'd0; mode_b = 2'd0;
    rgb_a = 24'h0; rgb_b = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("a_reset", adr_a, 32'h1000, dat_a, 32'(cyc_a), 32'(stb_a), 32'(busy_a), 32'(fd_a),
            32'(cti_a), 32'(we_a), 32'(sel_a), 32'(bte_a));
    chk_rst("b_reset", adr_b, 32'h0, dat_b, 32'(cyc_b), 32'(stb_b), 32'(busy_b), 32'(fd_b),
            32'(cti_b), 32'(we_b), 32'(sel_b), 32'(bte_b));
    rst_a = 1'b0; rst_b = 1'b0;

    // ---------------- Instance A: three frames, stall, mode changes ----------------
    for (int b = 0; b < 120; b++)
      q_a.push_back('{beat: b, adr: 32'h1000 + 32'(4 * (b % 40)), dat: exp_dat_a(b), fd: (b % 40 == 39)});
    for (int f = 0; f < 3; f++) begin
      ten_a.push_back(16); ten_a.push_back(16); ten_a.push_back(8);
    end
    mode_a = 2'd3; rgb_a = 24'h12_3456; en_a = 1'b1;

    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (cyc_a && adr_a == 32'h1050) break;
    end
    if (k == 200) chk("a_timeout_stall_point", adr_a, 32'h1050);
    ack_a = 1'b0; mode_a = 2'd0; rgb_a = 24'hAB_CDEF;
    repeat (5) begin
      @(posedge clk); #1;
      chk("a_stall_cyc", 32'(cyc_a), 32'd1);
      chk("a_stall_adr", adr_a, 32'h1050);
      chk("a_stall_dat", dat_a, 32'h0012_3456);
    end
    ack_a = 1'b1;
    wait_cnt(1'b0, 50, 200);
    mode_a = 2'd2;
    wait_cnt(1'b0, 90, 200);
    en_a = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (!busy_a) break;
      @(posedge clk); #1;
    end
    if (k == 200) chk("a_timeout_busy_drop", 32'(busy_a), 32'd0);
    chk("a_total_beats", cnt_a, 32'd120);
    chk("a_adr_wrapped", adr_a, 32'h1000);
    chk("a_queue_left", q_a.size(), 32'd0);
    chk("a_tenures_left", ten_a.size(), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("a_idle_cyc", 32'(cyc_a), 32'd0);
    end

    // ---------------- Instance B: reset at pixel 37 ----------------
    mode_b = 2'd0; en_b = 1'b1;
    push_b(0, 32'h00FF_FFFF);
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (cyc_b && adr_b == 32'd148) break;
    end
    if (k == 300) chk("b_timeout_pixel37", adr_b, 32'd148);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk_rst("b_midburst_reset", adr_b, 32'h0, dat_b, 32'(cyc_b), 32'(stb_b), 32'(busy_b), 32'(fd_b),
            32'(cti_b), 32'(we_b), 32'(sel_b), 32'(bte_b));

    // ---------------- Instance B: colour bars on line 0 ----------------
    mode_b = 2'd1;
    push_b(0,   32'h00FF_FFFF);
    push_b(99,  32'h00FF_FFFF);
    push_b(100, 32'h00FF_FF00);
    push_b(199, 32'h00FF_FF00);
    push_b(200, 32'h0000_FFFF);
    push_b(300, 32'h0000_FF00);
    push_b(400, 32'h00FF_00FF);
    push_b(500, 32'h00FF_0000);
    push_b(600, 32'h0000_00FF);
    push_b(700, 32'h0000_0000);
    push_b(799, 32'h0000_0000);
    push_b(800, 32'h00FF_FFFF);
    rst_b = 1'b0;
    wait_cnt(1'b1, 805, 1000);
    chk("b_bars_queue_left", q_b.size(), 32'd0);

    // ---------------- Instance B: grid, fresh frame ----------------
    rst_b = 1'b1;
    @(posedge clk); #1;
    mode_b = 2'd0;
    push_b(0,     32'h00FF_FFFF);
    push_b(801,   32'h0000_0000);
    push_b(816,   32'h00FF_FFFF);
    push_b(2400,  32'h00FF_FFFF);
    push_b(2416,  32'h00FF_FFFF);
    push_b(2417,  32'h0000_0000);
    push_b(25605, 32'h00FF_FFFF);
    push_b(25606, 32'h00FF_FFFF);
    rst_b = 1'b0;
    wait_cnt(1'b1, 25610, 30000);
    en_b = 1'b0;
    chk("b_grid_queue_left", q_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mire_gen.md
Name: mire_gen

Overview:
Parametrised Wishbone-master test-pattern generator that writes full frames of 32-bit pixels (0x00RRGGBB) into the framebuffer in SDRAM. It sits on the same Wishbone bus as the video controller's read master. It writes in bursts of BURST_LEN pixels and then releases the bus for one cycle so the arbiter can serve the display reader. It supports four runtime-selectable patterns, a configurable base address, and continuous or stop-at-frame-end operation.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
BASE_ADR, 0, byte address of pixel (0,0); multiple of 4
BURST_LEN, 64, max acked writes per bus tenure; power of two, >=2
GRID_STEP, 16, grid pitch / checker square size in pixels; power of two

Ports:
clk  in  1  system clock (wshb_ifm.clk)
rst  in  1  synchronous active-high reset (wshb_ifm.rst)
enable  in  1  run request; level-sensitive
mode  in  2  pattern: 0 grid, 1 colour bars, 2 checkerboard, 3 solid
solid_rgb  in  24  colour for mode 3
adr  out  32  Wishbone byte address
dat_ms  out  32  write data
we  out  1  constant 1
sel  out  4  constant 4'b1111
cyc  out  1  bus cycle
stb  out  1  strobe, always equal to cyc
cti  out  3  cycle type (see Optional Feature)
bte  out  2  constant 2'b00
ack  in  1  slave acknowledge
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse on the last ack of a frame

Behaviour:
- Single clock. Every flop resets synchronously on rst=1.
- Reset values: cyc=stb=0, adr=BASE_ADR, pix=0, line=0, burst count=0, mode_q=0, busy=0, frame_done=0, cti=000, state IDLE. After reset, dat_ms = 0x00FFFFFF (grid pixel (0,0)).
- FSM states: IDLE, BURST, RELEASE.
- IDLE: cyc=0. If enable=1, latch mode->mode_q and solid_rgb->rgb_q, set busy=1, go to BURST next cycle.
- BURST: cyc=stb=1. adr and dat_ms reflect the current pixel. On each ack:
  - pix increments; at HDISP-1 it wraps to 0 and line increments; at (HDISP-1,VDISP-1) both wrap to 0.
  - adr increases by 4; after the last pixel it wraps to BASE_ADR.
  - burst count increments.
- BURST exit conditions:
  - burst count reaches BURST_LEN, or the last pixel of the frame is acked -> RELEASE, with cyc=0 from the next cycle.
  - Final burst of a frame may be shorter when HDISP*VDISP is not a multiple of BURST_LEN.
- RELEASE: exactly one cycle with cyc=stb=0. Burst count clears.
  - If the frame completed and enable=0 -> IDLE, busy=0.
  - If the frame completed and enable=1 -> re-latch mode/solid_rgb, then BURST.
  - Otherwise -> BURST.
- Mode and colour are only sampled at frame start. Changes mid-frame have no effect until the next frame.
- enable deasserted mid-frame: the current frame finishes, then IDLE.
- frame_done=1 for the single cycle in which the ack of pixel (HDISP-1,VDISP-1) is sampled.
- No ack during BURST: outputs hold indefinitely. ack outside BURST is ignored.
- Address: adr = BASE_ADR + 4*(line*HDISP+pix). Maintained incrementally, not by multiplier.
- Patterns (combinational from pix, line, mode_q):
  - 0 grid: 0x00FFFFFF if pix%GRID_STEP==0 or line%GRID_STEP==0, else 0x00000000.
  - 1 bars: index = (pix*8)/HDISP. Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 (upper byte 0).
  - 2 checker: white if bit0 of ((pix/GRID_STEP) xor (line/GRID_STEP)) is 1, else black.
  - 3 solid: {8'h00, rgb_q}.
- Reset mid-burst: cyc drops the cycle after rst is sampled. The next frame restarts at BASE_ADR.

Optional Feature:
Macro MIRE_GEN_CTI_BURST_EN.
- Defined: during BURST, cti=3'b010 (incrementing burst), and cti=3'b111 on the final beat of each tenure (burst count = BURST_LEN-1, or the last pixel of the frame). bte stays 2'b00.
- Undefined: cti=3'b000 (classic cycle) at all times.

Test Plan:
1. HDISP=10, VDISP=4, BURST_LEN=16, ack always 1, enable=1 then 0 -> tenures of 16, 16 and 8 acks, each followed by exactly one cyc=0 cycle; frame_done pulses on the 40th ack; adr sequence 0,4,...,156; then IDLE with busy=0.
2. Mode 0, defaults, capture a frame -> pixel (16,3)=0x00FFFFFF, (17,3)=0x00000000, (5,32)=0x00FFFFFF.
3. Mode 1, HDISP=800 -> pixel 99=0x00FFFFFF, 100=0x00FFFF00, 799=0x00000000.
4. Mode 3 with solid_rgb=0x123456; switch mode to 0 mid-frame -> the whole frame is 0x00123456; the next frame is grid.
5. ack held low for 5 cycles mid-burst -> adr, dat_ms and cyc are stable for those cycles; BASE_ADR=0x1000 -> first adr=0x1000, wrap back to 0x1000 after the last pixel.
6. rst pulsed during a burst at pixel 37 -> cyc=0 the next cycle; after restart the first adr=BASE_ADR; with MIRE_GEN_CTI_BURST_EN defined, cti=010 on beats 0..62 and 111 on beat 63.
